fifo_rr_arb: RTL
================

Name: fifo_rr_arb

Overview:
- Shares the single write port of a pointer-managed circular FIFO between nreq producers, using round-robin arbitration.
- Contains the storage array, the write/read pointers and the arbiter. One consumer drains the FIFO through a first-word-fall-through read port.
- Sits between several request sources (for example, per-channel event generators) and one downstream consumer in the sys_clk domain.

Parameters:
- size, 5, ring length in slots. Usable capacity is size-1 entries; one slot always stays empty to tell full from empty.
- width, 8, data word width in bits.
- nreq, 4, number of requesters (2..8).

Ports:
- clk  input  1  system clock. All state changes on posedge.
- rst  input  1  synchronous, active-high reset, sampled on posedge clk.
- req  input  nreq  per-requester write request. Held with its din slice until the matching gnt bit.
- din  input  nreq*width  packed data. Requester k occupies bits [k*width +: width].
- gnt  output  nreq  one-hot, combinational. The bit is high in the cycle that requester's word is written.
- rd  input  1  consumer pop request.
- dout  output  width  combinational, equals mem[r_ptr]. Valid only while empty=0.
- full  output  1  high when w_ptr_next == r_ptr.
- empty  output  1  high when w_ptr == r_ptr.
- count  output  $clog2(size)+1  registered number of stored entries, 0..size-1.
- rd_err  output  1  sticky flag: rd was asserted while empty.

Behaviour:
- Pointers: w_ptr and r_ptr are $clog2(size)+1 bits wide. next = ptr+1, wrapping to 0 when next == size. Non-power-of-two size must work.
- Reset (rst=1 at posedge):
  - w_ptr=0, r_ptr=0, count=0, rd_err=0, last=nreq-1.
  - Resulting outputs: empty=1, full=0.
  - gnt is forced to 0 in any cycle with rst=1.
  - Reset mid-operation discards all stored data. Requests held across reset are re-arbitrated starting from requester 0.
- Arbitration (combinational):
  - If rst=0, full=0 and any req bit is set, grant the first set bit scanning last+1, last+2, ... modulo nreq.
  - Exactly one gnt bit is high, otherwise none.
  - No grant while full, even if rd=1 in the same cycle; there is no full bypass.
- Write (posedge, gnt!=0):
  - mem[w_ptr] <= granted din slice.
  - w_ptr <= w_ptr_next.
  - last <= index of granted requester.
  - last is unchanged when no grant occurs.
- Read (posedge, rd=1 and empty=0): r_ptr <= r_ptr_next.
  - The next entry appears on dout the following cycle.
  - Latency: a word written at edge N is visible on dout, with empty=0, after edge N.
- Invalid read (rd=1 and empty=1):
  - Pointers do not move.
  - rd_err <= 1, held until rst.
- Simultaneous write and read: both take effect at the same edge and count is unchanged. When empty, the read is ignored (and flagged), so count only increments.
- count updates:
  - +1 on write only.
  - -1 on valid read only.
  - Unchanged on both or neither.
  - Invariant: count equals (w_ptr - r_ptr) mod size.
- Fairness: a requester holding req is granted within nreq non-full write cycles.

Decomposition:
- Shared package holds:
  - a ptr-width helper constant function, $clog2(size)+1;
  - a round-robin one-hot select function (request vector plus last index gives grant vector), reused by later arbiters.
- Sub-module: the existing fifoctrl block (parameter size). It supplies full, empty, w_ptr_next and r_ptr_next from the registered pointers.
- This block owns the pointer registers, the storage, count, rd_err and the arbiter.

Test Plan:
1. Reset then idle, with rst held 2 cycles:
   - During reset: empty=1, full=0, count=0, gnt=0 even with req=4'b1111.
   - First post-reset grant: gnt=4'b0001.
2. Round robin with req=4'b1111, din = k+8'hA0 per requester k, rd=0:
   - Grants 0001, 0010, 0100, 1000 on consecutive cycles.
   - full=1 and count=4 after 4 writes; the fifth cycle has gnt=0.
3. Drain and wrap:
   - From the full state of scenario 2, pulse rd 4 times: dout shows A0, A1, A2, A3, then empty=1.
   - Refill 3 words: w_ptr wraps 4 -> 0 correctly and data reads back in order.
4. Simultaneous read and write:
   - With count=2 and req=4'b0100, rd=1 for 3 cycles: count stays 2 and gnt=0100 each cycle.
   - Then with count=4 (full) and rd=1, req set: gnt=0 that cycle, count=3 after the edge.
5. Underflow: with empty=1 pulse rd once -> rd_err=1 and pointers unchanged. rd_err stays 1 until rst.
6. Fairness under partial request:
   - req=4'b1010 continuously with rd=1 every cycle: grants alternate 0010, 1000, 0010, ...
   - Mid-stream rst: next grant is 0010 (scan from requester 0) and count=0.

Source files
------------

// File: rtl/fifo_rr_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rr_arb_pkg
// Purpose  : Shared constants and helpers for the round-robin FIFO writer.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_rr_arb_pkg;

    localparam int MAX_REQ = 8;

    function automatic int ptr_width(input int size);
        return $clog2(size) + 1;
    endfunction

    // One-hot round-robin pick: first set request after 'last', modulo n.
    function automatic logic [MAX_REQ-1:0] rr_select(
        input logic [MAX_REQ-1:0] req,
        input int                 n,
        input int                 last
    );
        logic [MAX_REQ-1:0] g;
        logic               found;
        logic [2:0]         idx;
        g     = '0;
        found = 1'b0;
        for (int i = 1; i <= MAX_REQ; i++) begin
            if ((i <= n) && !found) begin
                idx = 3'((last + i) % n);
                if (req[idx]) begin
                    g[idx] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
        return g;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rr_arb_fifoctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rr_arb_fifoctrl
// Purpose  : Pointer increment/wrap and full/empty decode for a circular FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rr_arb_fifoctrl
    import fifo_rr_arb_pkg::*;
#(
    parameter int SIZE = 5,
    parameter int PW   = ptr_width(SIZE)
) (
    input  logic [PW-1:0] wr_ptr,
    input  logic [PW-1:0] rd_ptr,
    output logic [PW-1:0] wr_ptr_next,
    output logic [PW-1:0] rd_ptr_next,
    output logic          full,
    output logic          empty
);

    // Explicit wrap at SIZE so non-power-of-two rings work.
    assign wr_ptr_next = (wr_ptr == PW'(SIZE - 1)) ? '0 : wr_ptr + PW'(1);
    assign rd_ptr_next = (rd_ptr == PW'(SIZE - 1)) ? '0 : rd_ptr + PW'(1);

    assign full  = (wr_ptr_next == rd_ptr);
    assign empty = (wr_ptr == rd_ptr);

endmodule
`default_nettype wire

// File: rtl/fifo_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rr_arb
// Purpose  : Circular FWFT FIFO whose write port is shared round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rr_arb
    import fifo_rr_arb_pkg::*;
#(
    parameter int SIZE  = 5,
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   din,
    output logic [NREQ-1:0]         gnt,
    input  logic                    rd,
    output logic [WIDTH-1:0]        dout,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(SIZE):0]   count,
    output logic                    rd_err
);

    localparam int PW    = ptr_width(SIZE);
    localparam int AW    = PW - 1;
    localparam int DEPTH = 1 << AW;
    localparam int LW    = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]      wr_ptr_q, wr_ptr_d, wr_ptr_next;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d, rd_ptr_next;
    logic [PW-1:0]      count_q, count_d;
    logic [LW-1:0]      last_q, last_d;
    logic               rd_err_q, rd_err_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];

    logic [MAX_REQ-1:0] req_ext;
    logic [MAX_REQ-1:0] sel;
    logic [WIDTH-1:0]   wdata;
    logic [LW-1:0]      gidx;
    logic               wr_en;
    logic               rd_en;

    fifo_rr_arb_fifoctrl #(
        .SIZE (SIZE),
        .PW   (PW)
    ) u_ctrl (
        .wr_ptr      (wr_ptr_q),
        .rd_ptr      (rd_ptr_q),
        .wr_ptr_next (wr_ptr_next),
        .rd_ptr_next (rd_ptr_next),
        .full        (full),
        .empty       (empty)
    );

    always_comb begin
        req_ext           = '0;
        req_ext[NREQ-1:0] = req;
    end

    assign sel = rr_select(req_ext, NREQ, int'(last_q));
    // No full bypass: a same-cycle pop never frees a slot for this edge's write.
    assign gnt = (!rst && !full) ? sel[NREQ-1:0] : '0;

    always_comb begin
        wdata = '0;
        gidx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt[k]) begin
                wdata = din[k*WIDTH +: WIDTH];
                gidx  = LW'(k);
            end
        end
    end

    assign wr_en = |gnt;
    assign rd_en = rd && !empty;

    always_comb begin
        wr_ptr_d = wr_en ? wr_ptr_next : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_next : rd_ptr_q;
        last_d   = wr_en ? gidx : last_q;
        rd_err_d = rd_err_q | (rd & empty);
        count_d  = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + PW'(1);
            2'b01:   count_d = count_q - PW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= LW'(NREQ - 1);
            rd_err_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
            rd_err_q <= rd_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

    assign dout   = mem_q[rd_ptr_q[AW-1:0]];
    assign count  = count_q;
    assign rd_err = rd_err_q;

endmodule
`default_nettype wire
